tensor_job_sequencer: RTL

- Drives the 16-bit instruction stream of the tensor core controller for one complete matrix job:
  - load 18 operand bytes;
  - burst-write them;
  - issue one operate;
  - wait for the result;
  - burst-read it;
  - stream the 9 result bytes out.
- Sits between the host byte interface and the tensor core controller.
- Top level performs clock-phase splitting of the paired words.

---
 rtl/tensor_job_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tensor_job_sequencer.sv
// Sequences one tensor-core job: operand load, burst write, operate, burst read, result drain.
// Every instruction word is registered from the next-state decode so it lines up with its state.
module tensor_job_sequencer #(
    parameter int OP_LATENCY = 3
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        job_valid_in,
    output logic        job_ready_out,
    input  logic [1:0]  job_opsel_in,
    input  logic        job_reuse_in,
    input  logic        operand_valid_in,
    input  logic [7:0]  operand_data_in,
    output logic        operand_ready_out,
    output logic [15:0] instruction_out,
    output logic [15:0] instruction_neg_out,
    input  logic [15:0] result_pair_in,
    output logic        result_valid_out,
    output logic [7:0]  result_data_out,
    output logic        result_last_out,
    input  logic        result_ready_in,
    output logic        busy_out,
    output logic [15:0] job_count_out
);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LOAD  = 4'd1;
    localparam logic [3:0] S_WCMD  = 4'd2;
    localparam logic [3:0] S_WDATA = 4'd3;
    localparam logic [3:0] S_OPER  = 4'd4;
    localparam logic [3:0] S_WAIT  = 4'd5;
    localparam logic [3:0] S_RCMD  = 4'd6;
    localparam logic [3:0] S_RDATA = 4'd7;
    localparam logic [3:0] S_DRAIN = 4'd8;

    localparam logic [15:0] NOP_WORD   = 16'h0000;
    localparam logic [15:0] WRITE_WORD = 16'h0006;
    localparam logic [15:0] READ_WORD  = 16'h0002;
    localparam int          WAIT_W     = $clog2(OP_LATENCY + 1);

    logic [3:0]         state, state_nxt;
    logic [2:0]         beat, beat_nxt;
    logic [4:0]         byte_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [3:0]         drain_idx;
    logic [1:0]         opsel_q, opsel_nxt;
    logic [17:0][7:0]   staging;
    logic [8:0][7:0]    result;
    logic [19:0][7:0]   stage_ext;
    logic [4:0]         base;
    logic [15:0]        word_nxt, neg_nxt;
    logic               job_accept, operand_accept, result_accept, wait_done, last_byte, last_result;

    assign job_accept     = job_valid_in && (state == S_IDLE);
    assign operand_accept = operand_valid_in && (state == S_LOAD);
    assign result_accept  = result_ready_in && (state == S_DRAIN);
    assign last_byte      = (byte_cnt == 5'd17);
    assign last_result    = (drain_idx == 4'd8);
    assign wait_done      = (wait_cnt == WAIT_W'(OP_LATENCY - 1));
    // Bytes 18 and 19 pad the final write beat with zeros.
    assign stage_ext      = {16'h0000, staging};

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        case (state)
            S_IDLE:  if (job_valid_in) state_nxt = job_reuse_in ? S_OPER : S_LOAD;
            S_LOAD:  if (operand_valid_in && last_byte) state_nxt = S_WCMD;
            S_WCMD: begin
                state_nxt = S_WDATA;
                beat_nxt  = 3'd0;
            end
            S_WDATA: begin
                if (beat == 3'd4) begin
                    state_nxt = S_OPER;
                    beat_nxt  = 3'd0;
                end else begin
                    beat_nxt = beat + 3'd1;
                end
            end
            S_OPER:  state_nxt = S_WAIT;
            S_WAIT:  if (wait_done) state_nxt = S_RCMD;
            S_RCMD: begin
                state_nxt = S_RDATA;
                beat_nxt  = 3'd0;
            end
            S_RDATA: begin
                if (beat == 3'd4) begin
                    state_nxt = S_DRAIN;
                    beat_nxt  = 3'd0;
                end else begin
                    beat_nxt = beat + 3'd1;
                end
            end
            S_DRAIN: if (result_ready_in && last_result) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A reuse job goes IDLE->OPERATE directly, so the select must bypass opsel_q.
    always_comb begin
        opsel_nxt = (state == S_IDLE) ? job_opsel_in : opsel_q;
        base      = {beat_nxt, 2'b00};
        word_nxt  = NOP_WORD;
        neg_nxt   = 16'h0000;
        case (state_nxt)
            S_WCMD:  word_nxt = WRITE_WORD;
            S_WDATA: begin
                neg_nxt  = {stage_ext[base], stage_ext[base + 5'd1]};
                word_nxt = {stage_ext[base + 5'd2], stage_ext[base + 5'd3]};
            end
            S_OPER:  word_nxt = {12'h000, opsel_nxt, 2'b01};
            S_RCMD:  word_nxt = READ_WORD;
            default: ;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state               <= S_IDLE;
            beat                <= '0;
            byte_cnt            <= '0;
            wait_cnt            <= '0;
            drain_idx           <= '0;
            opsel_q             <= '0;
            staging             <= '0;
            result              <= '0;
            instruction_out     <= NOP_WORD;
            instruction_neg_out <= '0;
            job_count_out       <= '0;
        end else begin
            state               <= state_nxt;
            beat                <= beat_nxt;
            instruction_out     <= word_nxt;
            instruction_neg_out <= neg_nxt;
            if (job_accept) opsel_q <= job_opsel_in;
            if (operand_accept) begin
                staging[byte_cnt] <= operand_data_in;
                byte_cnt          <= last_byte ? 5'd0 : byte_cnt + 5'd1;
            end
            if (state == S_WAIT) wait_cnt <= wait_done ? '0 : wait_cnt + WAIT_W'(1);
            // The fifth pair's low half is element 0 wrapping around; drop it.
            if (state == S_RDATA) begin
                result[{beat, 1'b0}] <= result_pair_in[15:8];
                if (beat != 3'd4) result[{beat, 1'b1}] <= result_pair_in[7:0];
            end
            if (result_accept) begin
                drain_idx <= last_result ? 4'd0 : drain_idx + 4'd1;
                if (last_result) job_count_out <= job_count_out + 16'd1;
            end
        end
    end

    assign job_ready_out     = (state == S_IDLE);
    assign operand_ready_out = (state == S_LOAD);
    assign busy_out          = (state != S_IDLE);
    assign result_valid_out  = (state == S_DRAIN);
    assign result_data_out   = result[drain_idx];
    assign result_last_out   = (state == S_DRAIN) && last_result;

endmodule
